// File: rtl/hash_ctrl_if.sv
// Message-in / digest-out handshake bundle for hash_ctrl.
// master: byte producer + digest consumer; slave: the controller.
interface hash_ctrl_if;
  logic [7:0]      msg_byte;
  logic            msg_valid;
  logic            msg_last;
  logic            msg_ready;
  logic [3:0][7:0] digest;
  logic            digest_valid;
  logic            digest_ack;

  modport master (
    output msg_byte, msg_valid, msg_last, digest_ack,
    input  msg_ready, digest, digest_valid
  );

  modport slave (
    input  msg_byte, msg_valid, msg_last, digest_ack,
    output msg_ready, digest, digest_valid
  );
endinterface

// File: rtl/hash_ctrl.sv
// Hash round controller: buffers 4-byte blocks, pads, sequences rounds.
// Ports: clk, reset (async low), msg (slave bus), state_o, h_blk, iv, h_round.
module hash_ctrl #(
  parameter int unsigned  NUM_ROUNDS = 4,
  parameter logic [31:0]  IV_INIT    = 32'h6A09_E667
) (
  input  logic            clk,
  input  logic            reset,
  hash_ctrl_if.slave      msg,
  output logic [2:0]      state_o,
  output logic [3:0][7:0] h_blk,
  output logic [3:0][7:0] iv,
  input  logic [3:0][7:0] h_round
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SA, ROUND, FINAL, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] blk_q, blk_d;
  logic [3:0][7:0] cv_q, cv_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [1:0]      idx_q, idx_d;
  logic            last_q, last_d;
  logic            pad_q, pad_d;
  logic            acc;
  int              p;

  assign acc = msg.msg_valid & msg.msg_ready;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    cv_d    = cv_q;
    rnd_d   = rnd_q;
    idx_d   = idx_q;
    last_d  = last_q;
    pad_d   = pad_q;
    p       = int'(idx_q);
    unique case (state_q)
      IDLE, LOAD: begin
        if (acc) begin
          // index 0 lives in the top byte
          blk_d[2'd3 - idx_q] = msg.msg_byte;
          if (msg.msg_last) begin
            state_d = SA;
            idx_d   = 2'd0;
            if (idx_q == 2'd3) begin
              // no room left: padding goes in an extra block
              pad_d = 1'b1;
            end else begin
              last_d = 1'b1;
              for (int i = 0; i < 4; i++) begin
                if (i == p + 1)
                  blk_d[2'(3 - i)] = 8'h80;
                else if (i > p + 1)
                  blk_d[2'(3 - i)] = 8'h00;
              end
            end
          end else if (idx_q == 2'd3) begin
            state_d = SA;
            idx_d   = 2'd0;
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      SA: begin
        state_d = ROUND;
        rnd_d   = 4'd0;
      end
      ROUND: begin
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(NUM_ROUNDS - 1))
          state_d = FINAL;
      end
      FINAL: begin
        cv_d  = h_round;
        rnd_d = 4'd0;
        if (pad_q) begin
          pad_d   = 1'b0;
          blk_d   = 32'h8000_0000;
          last_d  = 1'b1;
          state_d = SA;
        end else if (last_q) begin
          state_d = DONE;
        end else begin
          idx_d   = 2'd0;
          state_d = LOAD;
        end
      end
      DONE: begin
        if (msg.digest_ack) begin
          cv_d    = IV_INIT;
          last_d  = 1'b0;
          idx_d   = 2'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      blk_q   <= '0;
      cv_q    <= IV_INIT;
      rnd_q   <= 4'd0;
      idx_q   <= 2'd0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cv_q    <= cv_d;
      rnd_q   <= rnd_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
    end
  end

  always_comb begin
    state_o = 3'b000;
    h_blk   = '0;
    unique case (state_q)
      SA: begin
        state_o = 3'b001;
        h_blk   = blk_q;
      end
      ROUND: begin
        state_o = 3'b010;
        h_blk   = h_round;
      end
      FINAL:   state_o = 3'b011;
      DONE:    state_o = 3'b100;
      default: state_o = 3'b000;
    endcase
  end

  // gated by reset so the port reads 0 while reset is held
  assign msg.msg_ready    = reset &
                            ((state_q == IDLE) || (state_q == LOAD));
  assign msg.digest_valid = (state_q == DONE);
  assign msg.digest       = (state_q == DONE) ? cv_q : '0;
  assign iv               = cv_q;

endmodule

// File: tb/tb_hash_ctrl.sv
// Directed self-checking bench for hash_ctrl.
// Drives bytes/acks via hash_ctrl_if, plays a constant round datapath.
module tb_hash_ctrl;

  localparam logic [31:0] IVI = 32'h6A09_E667;

  logic        clk;
  logic        rst;
  logic [31:0] h_round;
  logic [31:0] h_blk;
  logic [31:0] iv;
  logic [2:0]  state_o;
  int          n_cmp;
  int          n_bad;

  hash_ctrl_if bus ();

  hash_ctrl #(
    .NUM_ROUNDS (4),
    .IV_INIT    (IVI)
  ) dut (
    .clk     (clk),
    .reset   (rst),
    .msg     (bus),
    .state_o (state_o),
    .h_blk   (h_blk),
    .iv      (iv),
    .h_round (h_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    bus.msg_byte  = b;
    bus.msg_last  = last;
    bus.msg_valid = 1'b1;
    while (!bus.msg_ready && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("send_timeout", 32'(bus.msg_ready), 1);
    tick();
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.digest_valid && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("done_timeout", 32'(bus.digest_valid), 1);
  endtask

  task automatic ack();
    bus.digest_ack = 1'b1;
    tick();
    bus.digest_ack = 1'b0;
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_bad = 0;
    rst            = 1'b0;
    bus.msg_byte   = 8'h00;
    bus.msg_valid  = 1'b0;
    bus.msg_last   = 1'b0;
    bus.digest_ack = 1'b0;
    h_round        = 32'hDEAD_BEEF;
    tick();
    tick();

    // reset values
    chk("rst_state", 32'(state_o), 0);
    chk("rst_ready", 32'(bus.msg_ready), 0);
    chk("rst_dv", 32'(bus.digest_valid), 0);
    chk("rst_digest", bus.digest, 0);
    chk("rst_hblk", h_blk, 0);
    chk("rst_iv", iv, IVI);
    rst = 1'b1;
    tick();
    chk("rel_ready", 32'(bus.msg_ready), 1);

    // 61 62 63 + last
    send(8'h61, 1'b0);
    chk("load_state", 32'(state_o), 0);
    chk("load_ready", 32'(bus.msg_ready), 1);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    lat = 1;
    chk("sa_state", 32'(state_o), 1);
    chk("sa_hblk", h_blk, 32'h6162_6380);
    chk("sa_ready", 32'(bus.msg_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      lat++;
      chk("round_state", 32'(state_o), 2);
      chk("round_hblk", h_blk, 32'hDEAD_BEEF);
    end
    tick();
    lat++;
    chk("final_state", 32'(state_o), 3);
    tick();
    lat++;
    chk("done_state", 32'(state_o), 4);
    chk("done_dv", 32'(bus.digest_valid), 1);
    chk("dv_latency", 32'(lat), 7);

    // digest held without ack
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_digest", bus.digest, 32'hDEAD_BEEF);
      chk("hold_dv", 32'(bus.digest_valid), 1);
      chk("hold_ready", 32'(bus.msg_ready), 0);
    end
    ack();
    chk("ack_state", 32'(state_o), 0);
    chk("ack_iv", iv, IVI);
    chk("ack_dv", 32'(bus.digest_valid), 0);

    // ack ignored in IDLE and LOAD
    ack();
    chk("idle_ack_state", 32'(state_o), 0);
    chk("idle_ack_ready", 32'(bus.msg_ready), 1);
    send(8'hB1, 1'b0);
    ack();
    chk("load_ack_ready", 32'(bus.msg_ready), 1);
    send(8'hB2, 1'b1);
    chk("ign_sa_hblk", h_blk, 32'hB1B2_8000);
    h_round = 32'h0F0F_0F0F;
    wait_done();
    chk("ign_digest", bus.digest, 32'h0F0F_0F0F);
    ack();

    // full block + last: padding block follows
    h_round = 32'h1122_3344;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    chk("pad1_hblk", h_blk, 32'h0102_0304);
    chk("pad1_iv", iv, IVI);
    for (int i = 0; i < 6; i++) tick();
    chk("pad2_state", 32'(state_o), 1);
    chk("pad2_hblk", h_blk, 32'h8000_0000);
    chk("pad2_iv", iv, 32'h1122_3344);
    h_round = 32'h5566_7788;
    wait_done();
    chk("pad_digest", bus.digest, 32'h5566_7788);
    ack();

    // two blocks with gaps, valid held while busy
    h_round = 32'hA0A0_A0A0;
    for (int i = 0; i < 4; i++) begin
      tick();
      send(8'hA1 + 8'(i), 1'b0);
    end
    chk("blk1_hblk", h_blk, 32'hA1A2_A3A4);
    bus.msg_byte  = 8'hA5;
    bus.msg_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("busy_ready", 32'(bus.msg_ready), 0);
      tick();
    end
    chk("blk2_load", 32'(state_o), 0);
    for (int i = 0; i < 4; i++) begin
      send(8'hA5 + 8'(i), i == 3);
      if (i < 3) tick();
    end
    chk("blk2_hblk", h_blk, 32'hA5A6_A7A8);
    wait_done();
    chk("blk2_digest", bus.digest, 32'hA0A0_A0A0);
    ack();

    // reset in the 2nd ROUND cycle
    h_round = 32'h1357_9BDF;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    tick();
    tick();
    chk("pre_rst_state", 32'(state_o), 2);
    chk("pre_rst_iv", iv, IVI);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_ready", 32'(bus.msg_ready), 0);
    chk("mid_rst_hblk", h_blk, 0);
    chk("mid_rst_dv", 32'(bus.digest_valid), 0);
    chk("mid_rst_digest", bus.digest, 0);
    chk("mid_rst_iv", iv, IVI);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.msg_ready), 1);
    h_round = 32'hCAFE_F00D;
    send(8'h5A, 1'b1);
    chk("post_rst_hblk", h_blk, 32'h5A80_0000);
    chk("post_rst_iv", iv, IVI);
    wait_done();
    chk("post_rst_digest", bus.digest, 32'hCAFE_F00D);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
